// File: rtl/swc_page_usecnt_allocator_pkg.sv
// Shared types and default widths for the page use-count allocator.
package swc_page_alloc_pkg;

    localparam int unsigned C_PAGE_ADDR_WIDTH = 10;
    localparam int unsigned C_USECNT_WIDTH    = 4;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        RECOVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ALLOC        = 2'd0,
        FREE         = 2'd1,
        FORCE_FREE   = 2'd2,
        SET_USECOUNT = 2'd3
    } req_t;

endpackage

// File: rtl/swc_page_usecnt_allocator_if.sv
// Request/response bus between a requester and the page allocator.
interface swc_page_usecnt_allocator_if #(
    parameter int unsigned g_page_addr_width = swc_page_alloc_pkg::C_PAGE_ADDR_WIDTH,
    parameter int unsigned g_usecnt_width    = swc_page_alloc_pkg::C_USECNT_WIDTH
);
    logic                         alloc_i;
    logic                         free_i;
    logic                         force_free_i;
    logic                         set_usecnt_i;
    logic [g_page_addr_width-1:0] pg_addr_i;
    logic [g_usecnt_width-1:0]    usecnt_i;
    logic                         done_o;
    logic                         alloc_done_o;
    logic                         free_done_o;
    logic                         force_free_done_o;
    logic                         set_usecnt_done_o;
    logic [g_page_addr_width-1:0] pg_addr_alloc_o;
    logic                         free_last_usecnt_o;
    logic                         no_mem_o;
    logic                         err_o;
    logic [g_page_addr_width:0]   free_pages_o;

    modport master (
        output alloc_i, free_i, force_free_i, set_usecnt_i, pg_addr_i, usecnt_i,
        input  done_o, alloc_done_o, free_done_o, force_free_done_o, set_usecnt_done_o,
        input  pg_addr_alloc_o, free_last_usecnt_o, no_mem_o, err_o, free_pages_o
    );

    modport slave (
        input  alloc_i, free_i, force_free_i, set_usecnt_i, pg_addr_i, usecnt_i,
        output done_o, alloc_done_o, free_done_o, force_free_done_o, set_usecnt_done_o,
        output pg_addr_alloc_o, free_last_usecnt_o, no_mem_o, err_o, free_pages_o
    );
endinterface

// File: rtl/swc_page_usecnt_allocator_free_stack.sv
// LIFO of free page numbers; the init fill makes pops return 0,1,2,... in order.
module swc_alloc_free_stack #(
    parameter int unsigned g_addr_width = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    init_i,
    input  logic                    push_i,
    input  logic [g_addr_width-1:0] push_page_i,
    input  logic                    pop_i,
    output logic [g_addr_width-1:0] pop_page_o,
    output logic [g_addr_width:0]   count_o,
    output logic [g_addr_width-1:0] init_addr_o,
    output logic                    init_last_o
);
    localparam int unsigned                C_DEPTH = 2**g_addr_width;
    localparam logic [g_addr_width:0]      C_FULL  = C_DEPTH[g_addr_width:0];

    logic [g_addr_width-1:0] r_mem [C_DEPTH];
    logic [g_addr_width:0]   r_top;
    logic [g_addr_width-1:0] r_init_cnt;
    logic [g_addr_width-1:0] r_pop_page;
    logic [g_addr_width-1:0] w_top_idx;
    logic                    w_can_pop;
    logic                    w_can_push;

    assign w_top_idx   = r_top[g_addr_width-1:0] - 1'b1;
    assign w_can_pop   = (r_top != {(g_addr_width+1){1'b0}});
    assign w_can_push  = (r_top != C_FULL);
    assign init_last_o = &r_init_cnt;
    assign init_addr_o = r_init_cnt;
    assign pop_page_o  = r_pop_page;
    assign count_o     = r_top;

    // Top pointer, init counter and registered pop result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_top      <= {(g_addr_width+1){1'b0}};
            r_init_cnt <= {g_addr_width{1'b0}};
            r_pop_page <= {g_addr_width{1'b0}};
        end else if (init_i) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (init_last_o) begin
                r_top <= C_FULL;
            end
        end else if (pop_i && w_can_pop) begin
            r_pop_page <= r_mem[w_top_idx];
            r_top      <= r_top - 1'b1;
        end else if (push_i && w_can_push) begin
            r_top <= r_top + 1'b1;
        end
    end

    // Storage: slot i gets page N-1-i so the deepest slot is popped last
    always_ff @(posedge clk_i) begin
        if (init_i) begin
            r_mem[r_init_cnt] <= ~r_init_cnt;
        end else if (push_i && w_can_push) begin
            r_mem[r_top[g_addr_width-1:0]] <= push_page_i;
        end
    end
endmodule

// File: rtl/swc_page_usecnt_allocator.sv
// Page allocator with per-page use counts: arbitrates requests, keeps {valid, usecnt} per page.
module swc_page_usecnt_allocator
    import swc_page_alloc_pkg::*;
#(
    parameter int unsigned g_page_addr_width = C_PAGE_ADDR_WIDTH,
    parameter int unsigned g_usecnt_width    = C_USECNT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    swc_page_usecnt_allocator_if.slave bus
);
    localparam int unsigned AW = g_page_addr_width;
    localparam int unsigned UW = g_usecnt_width;
    localparam int unsigned N  = 2**AW;
    localparam logic [UW-1:0] C_UC_ONE = {{(UW-1){1'b0}}, 1'b1};

    state_t           r_state, w_next_state;
    req_t             r_req, w_sel_req;
    logic [AW-1:0]    r_addr;
    logic [UW-1:0]    r_cnt;
    logic [UW:0]      r_ram [N];
    logic [UW:0]      r_rec;
    logic             w_any_req, w_valid, w_release, w_err;
    logic             w_ram_we;
    logic [AW-1:0]    w_ram_waddr;
    logic [UW:0]      w_ram_wdata;
    logic             w_init, w_pop, w_push, w_init_last;
    logic [AW-1:0]    w_pop_page, w_init_addr;
    logic [AW:0]      w_free_pages;
    logic             r_done, r_alloc_done, r_free_done, r_force_free_done, r_set_done;
    logic             r_err, r_free_last;
    logic [AW-1:0]    r_pg_addr_alloc;

    assign w_init = (r_state == INIT);
    assign w_pop  = (r_state == READ) && (r_req == ALLOC);
    assign w_push = (r_state == WRITE) && w_release;

    swc_alloc_free_stack #(.g_addr_width(AW)) u_stack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .init_i      (w_init),
        .push_i      (w_push),
        .push_page_i (r_addr),
        .pop_i       (w_pop),
        .pop_page_o  (w_pop_page),
        .count_o     (w_free_pages),
        .init_addr_o (w_init_addr),
        .init_last_o (w_init_last)
    );

    // Fixed-priority arbitration; alloc is only eligible while a page is free
    always_comb begin
        w_sel_req = ALLOC;
        w_any_req = 1'b0;
        if (bus.free_i) begin
            w_sel_req = FREE;
            w_any_req = 1'b1;
        end else if (bus.force_free_i) begin
            w_sel_req = FORCE_FREE;
            w_any_req = 1'b1;
        end else if (bus.set_usecnt_i) begin
            w_sel_req = SET_USECOUNT;
            w_any_req = 1'b1;
        end else if (bus.alloc_i && (w_free_pages != {(AW+1){1'b0}})) begin
            w_sel_req = ALLOC;
            w_any_req = 1'b1;
        end else begin
            w_sel_req = ALLOC;
            w_any_req = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            INIT:    w_next_state = w_init_last ? IDLE : INIT;
            IDLE:    w_next_state = w_any_req ? READ : IDLE;
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = RECOVER;
            RECOVER: w_next_state = IDLE;
            default: w_next_state = INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Decode the fetched record: release decision and invalid-page error
    always_comb begin
        w_valid   = r_rec[UW];
        w_release = 1'b0;
        w_err     = 1'b0;
        case (r_req)
            ALLOC:        w_err = 1'b0;
            FREE: begin
                w_release = w_valid && (r_rec[UW-1:0] <= C_UC_ONE);
                w_err     = !w_valid;
            end
            FORCE_FREE: begin
                w_release = w_valid;
                w_err     = !w_valid;
            end
            SET_USECOUNT: w_err = !w_valid;
            default:      w_err = 1'b0;
        endcase
    end

    // Use-count RAM write port: clears every record during INIT
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_addr;
        w_ram_wdata = {(UW+1){1'b0}};
        if (w_init) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_init_addr;
        end else if (r_state == WRITE) begin
            case (r_req)
                ALLOC: begin
                    w_ram_we    = 1'b1;
                    w_ram_waddr = w_pop_page;
                    w_ram_wdata = {1'b1, r_cnt};
                end
                FREE: begin
                    w_ram_we    = w_valid;
                    w_ram_wdata = w_release ? {(UW+1){1'b0}} : {1'b1, r_rec[UW-1:0] - C_UC_ONE};
                end
                FORCE_FREE:   w_ram_we = w_valid;
                SET_USECOUNT: begin
                    w_ram_we    = w_valid;
                    w_ram_wdata = {1'b1, r_cnt};
                end
                default:      w_ram_we = 1'b0;
            endcase
        end else begin
            w_ram_we = 1'b0;
        end
    end

    // Use-count RAM with registered read in READ
    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            r_ram[w_ram_waddr] <= w_ram_wdata;
        end
        if (r_state == READ) begin
            r_rec <= r_ram[r_addr];
        end
    end

    // Request latch and registered completion outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req             <= ALLOC;
            r_addr            <= {AW{1'b0}};
            r_cnt             <= {UW{1'b0}};
            r_done            <= 1'b0;
            r_alloc_done      <= 1'b0;
            r_free_done       <= 1'b0;
            r_force_free_done <= 1'b0;
            r_set_done        <= 1'b0;
            r_err             <= 1'b0;
            r_free_last       <= 1'b0;
            r_pg_addr_alloc   <= {AW{1'b0}};
        end else begin
            if ((r_state == IDLE) && w_any_req) begin
                r_req  <= w_sel_req;
                r_addr <= bus.pg_addr_i;
                r_cnt  <= bus.usecnt_i;
            end
            r_done            <= (r_state == WRITE);
            r_alloc_done      <= (r_state == WRITE) && (r_req == ALLOC);
            r_free_done       <= (r_state == WRITE) && (r_req == FREE);
            r_force_free_done <= (r_state == WRITE) && (r_req == FORCE_FREE);
            r_set_done        <= (r_state == WRITE) && (r_req == SET_USECOUNT);
            r_err             <= (r_state == WRITE) && w_err;
            r_free_last       <= (r_state == WRITE) && (r_req == FREE) && w_release;
            if ((r_state == WRITE) && (r_req == ALLOC)) begin
                r_pg_addr_alloc <= w_pop_page;
            end
        end
    end

    assign bus.done_o             = r_done;
    assign bus.alloc_done_o       = r_alloc_done;
    assign bus.free_done_o        = r_free_done;
    assign bus.force_free_done_o  = r_force_free_done;
    assign bus.set_usecnt_done_o  = r_set_done;
    assign bus.err_o              = r_err;
    assign bus.free_last_usecnt_o = r_free_last;
    assign bus.pg_addr_alloc_o    = r_pg_addr_alloc;
    assign bus.free_pages_o       = w_free_pages;
    assign bus.no_mem_o           = (w_free_pages == {(AW+1){1'b0}});
endmodule

// File: tb/tb_swc_page_usecnt_allocator.sv
// Randomised bench for the page allocator against a transaction-level page/stack model.
module tb_swc_page_usecnt_allocator;
    import swc_page_alloc_pkg::*;

    localparam int AW = 3;
    localparam int UW = 4;
    localparam int N  = 8;
    localparam int NEVER = 32'h3fff_ffff;

    typedef struct {
        int   cyc;
        req_t kind;
        bit   err;
        bit   last;
        int   page;
        int   fp;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    swc_page_usecnt_allocator_if #(.g_page_addr_width(AW), .g_usecnt_width(UW)) bus ();

    swc_page_usecnt_allocator #(.g_page_addr_width(AW), .g_usecnt_width(UW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int  vectors = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  rst_start = 0;
    int  init_end  = NEVER;
    bit  m_valid [N];
    int  m_uc    [N];
    int  m_stack [$];
    int  m_vis_alloc;
    ev_t evq [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_stack.delete();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_uc[i]    = 0;
            m_stack.push_back(i);
        end
        m_vis_alloc = 0;
        evq.delete();
    endfunction

    // One request's effect on the page table and free list
    function automatic ev_t model_apply(req_t k, int a, int c);
        ev_t e;
        e.kind = k; e.err = 1'b0; e.last = 1'b0; e.page = 0; e.cyc = 0;
        if (k == ALLOC) begin
            e.page = m_stack.pop_front();
            m_valid[e.page] = 1'b1;
            m_uc[e.page]    = c;
        end else if (!m_valid[a]) begin
            e.err = 1'b1;
        end else if (k == SET_USECOUNT) begin
            m_uc[a] = c;
        end else if (k == FORCE_FREE || m_uc[a] <= 1) begin
            m_valid[a] = 1'b0;
            m_uc[a]    = 0;
            m_stack.push_front(a);
            e.last = (k == FREE);
        end else begin
            m_uc[a] = m_uc[a] - 1;
        end
        e.fp = m_stack.size();
        return e;
    endfunction

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic [6:0] act_s, exp_s;
        ev_t e;
        act_s = {bus.done_o, bus.alloc_done_o, bus.free_done_o, bus.force_free_done_o,
                 bus.set_usecnt_done_o, bus.err_o, bus.free_last_usecnt_o};
        exp_s = 7'd0;
        if (cyc >= rst_start && cyc < init_end) begin
            chk("rst_strobes", 32'(act_s), 32'd0);
            chk("rst_free_pages", 32'(bus.free_pages_o), 32'd0);
            chk("rst_no_mem", 32'(bus.no_mem_o), 32'd1);
            chk("rst_pg_addr", 32'(bus.pg_addr_alloc_o), 32'd0);
        end else begin
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                exp_s[6] = 1'b1;
                case (e.kind)
                    ALLOC:        begin exp_s[5] = 1'b1; m_vis_alloc = e.page; end
                    FREE:         exp_s[4] = 1'b1;
                    FORCE_FREE:   exp_s[3] = 1'b1;
                    default:      exp_s[2] = 1'b1;
                endcase
                exp_s[1] = e.err;
                exp_s[0] = e.last;
                chk("done_free_pages", 32'(bus.free_pages_o), 32'(e.fp));
                chk("done_no_mem", 32'(bus.no_mem_o), 32'(e.fp == 0));
            end else if (evq.size() == 0) begin
                chk("idle_free_pages", 32'(bus.free_pages_o), 32'(m_stack.size()));
                chk("idle_no_mem", 32'(bus.no_mem_o), 32'(m_stack.size() == 0));
            end
            chk("strobes", 32'(act_s), 32'(exp_s));
            chk("pg_addr_alloc", 32'(bus.pg_addr_alloc_o), 32'(m_vis_alloc));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_req();
        bus.alloc_i = 1'b0; bus.free_i = 1'b0; bus.force_free_i = 1'b0; bus.set_usecnt_i = 1'b0;
    endtask

    task automatic drive(req_t k, int a, int c);
        bus.alloc_i      = (k == ALLOC);
        bus.free_i       = (k == FREE);
        bus.force_free_i = (k == FORCE_FREE);
        bus.set_usecnt_i = (k == SET_USECOUNT);
        bus.pg_addr_i    = AW'(a);
        bus.usecnt_i     = UW'(c);
    endtask

    // Raise a request with the DUT idle; done is due on the third edge, then one recovery cycle
    task automatic issue(req_t k, int a, int c);
        ev_t e;
        e = model_apply(k, a, c);
        e.cyc = cyc + 3;
        evq.push_back(e);
        drive(k, a, c);
        repeat (3) step();
        clear_req();
        step();
    endtask

    task automatic do_reset_release();
        rst = 1'b0;
        init_end = cyc + N;
        model_reset();
        repeat (N) step();
    endtask

    initial begin
        ev_t e1, e2;
        int  k, c, p;
        clear_req();
        bus.pg_addr_i = '0;
        bus.usecnt_i  = '0;
        model_reset();
        repeat (3) step();
        do_reset_release();
        chk("lit_init_free_pages", 32'(bus.free_pages_o), 32'd8);

        for (int i = 0; i < 3; i++) issue(ALLOC, 0, 2);
        chk("lit_third_alloc_page", 32'(bus.pg_addr_alloc_o), 32'd2);
        chk("lit_free_pages_after_3", 32'(bus.free_pages_o), 32'd5);

        issue(FREE, 1, 0);
        issue(FREE, 1, 0);
        chk("lit_free_pages_after_free", 32'(bus.free_pages_o), 32'd6);
        issue(ALLOC, 0, 1);
        chk("lit_realloc_page1", 32'(bus.pg_addr_alloc_o), 32'd1);

        issue(ALLOC, 0, 0);
        chk("lit_alloc_zero_page", 32'(bus.pg_addr_alloc_o), 32'd3);
        issue(SET_USECOUNT, 3, 3);
        issue(FREE, 3, 0);
        issue(FORCE_FREE, 3, 0);
        chk("lit_free_pages_restored", 32'(bus.free_pages_o), 32'd5);

        issue(FREE, 5, 0);
        chk("lit_err_free_pages", 32'(bus.free_pages_o), 32'd5);

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            p = $urandom_range(0, N - 1);
            if (k == 0 && m_stack.size() == 0) k = 2;
            issue(req_t'(k), p, c);
        end

        while (m_stack.size() > 0) issue(ALLOC, 0, 2);
        chk("lit_no_mem_full", 32'(bus.no_mem_o), 32'd1);
        chk("lit_free_pages_full", 32'(bus.free_pages_o), 32'd0);

        // Blocked alloc: nothing completes until a force_free releases page 3
        drive(ALLOC, 0, 1);
        repeat (6) step();
        e1 = model_apply(FORCE_FREE, 3, 0);
        e1.cyc = cyc + 3;
        e2 = model_apply(ALLOC, 0, 1);
        e2.cyc = cyc + 7;
        evq.push_back(e1);
        evq.push_back(e2);
        bus.force_free_i = 1'b1;
        bus.pg_addr_i    = AW'(3);
        repeat (3) step();
        bus.force_free_i = 1'b0;
        repeat (4) step();
        clear_req();
        step();
        chk("lit_blocked_alloc_page", 32'(bus.pg_addr_alloc_o), 32'd3);

        // Reset while an alloc is in READ: it must vanish without a done
        drive(ALLOC, 0, 2);
        step();
        rst = 1'b1;
        clear_req();
        init_end  = NEVER;
        rst_start = cyc + 1;
        repeat (2) step();
        do_reset_release();
        chk("lit_reinit_free_pages", 32'(bus.free_pages_o), 32'd8);
        issue(ALLOC, 0, 2);
        chk("lit_reinit_alloc_page", 32'(bus.pg_addr_alloc_o), 32'd0);
        chk("lit_reinit_free_after", 32'(bus.free_pages_o), 32'd7);

        if (evq.size() != 0) chk("event_queue_drained", 32'(evq.size()), 32'd0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
